// File: rtl/ttl74148_sync_pkg.sv
// Shared constants and types for the registered 74148 priority encoder.
// Also used by other switch-driven blocks that reuse vec_debounce.
package ttl74148_sync_pkg;

    typedef struct packed {
        logic [2:0] a_n;
        logic       gs_n;
        logic       eo_n;
    } code_t;

    localparam code_t      IDLE_CODE        = '{a_n: 3'b111, gs_n: 1'b1, eo_n: 1'b1};
    localparam logic [8:0] IDLE_VEC         = 9'h1FF;
    localparam int         DEBOUNCE_DEFAULT = 1000000;
    localparam int         DEBOUNCE_SIM     = 4;

endpackage

// File: rtl/vec_debounce.sv
// Two-flop synchroniser plus one shared stability counter for a W-bit switch vector.
// The whole vector is accepted only after it has stayed unchanged for DEBOUNCE_CYCLES edges.
module vec_debounce #(
    parameter int         W               = 9,
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [W-1:0] RESET_VAL     = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LOAD_AT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  SAT     = CW'(DEBOUNCE_CYCLES);

    logic [W-1:0]  meta_r;
    logic [W-1:0]  s_r;
    logic [W-1:0]  stable_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          load_s;

    // Stability is judged on the value entering the second stage, so the
    // count overlaps the synchroniser delay and a clean change lands
    // DEBOUNCE_CYCLES+2 edges after it is first sampled.
    always_comb begin
        cnt_next_s = cnt_r;
        load_s     = 1'b0;
        if (meta_r != s_r) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            if (cnt_r == LOAD_AT) begin
                load_s = 1'b1;
            end else begin
                load_s = 1'b0;
            end
            if (cnt_r != SAT) begin
                cnt_next_s = cnt_r + CW'(1);
            end else begin
                cnt_next_s = cnt_r;
            end
        end
    end

    // Synchroniser, counter and accepted-vector registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r   <= RESET_VAL;
            s_r      <= RESET_VAL;
            stable_r <= RESET_VAL;
            cnt_r    <= {CW{1'b0}};
        end else begin
            meta_r <= raw;
            s_r    <= meta_r;
            cnt_r  <= cnt_next_s;
            if (load_s) begin
                stable_r <= s_r;
            end
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/ttl74148_sync.sv
// Registered 8-to-3 priority encoder with 74148 pin semantics on debounced switches,
// plus a one-cycle change strobe and wrapping change counter.
module ttl74148_sync
    import ttl74148_sync_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ei_n,
    input  logic [7:0]       i_n,
    output logic [2:0]       a_n,
    output logic             gs_n,
    output logic             eo_n,
    output logic             chg,
    output logic [CNT_W-1:0] chg_cnt
);

    logic [8:0]       d_s;
    code_t            code_s;
    code_t            code_r;
    logic             chg_r;
    logic [CNT_W-1:0] chg_cnt_r;

    vec_debounce #(
        .W               (9),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (IDLE_VEC)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .raw    ({ei_n, i_n}),
        .stable (d_s)
    );

    // 74148 encode from the debounced vector; i_n[7] wins.
    always_comb begin
        code_s = IDLE_CODE;
        if (d_s[8]) begin
            code_s = IDLE_CODE;
        end else if (d_s[7:0] == 8'hFF) begin
            code_s = '{a_n: 3'b111, gs_n: 1'b1, eo_n: 1'b0};
        end else begin
            code_s.gs_n = 1'b0;
            code_s.eo_n = 1'b1;
            if      (!d_s[7]) code_s.a_n = 3'b000;
            else if (!d_s[6]) code_s.a_n = 3'b001;
            else if (!d_s[5]) code_s.a_n = 3'b010;
            else if (!d_s[4]) code_s.a_n = 3'b011;
            else if (!d_s[3]) code_s.a_n = 3'b100;
            else if (!d_s[2]) code_s.a_n = 3'b101;
            else if (!d_s[1]) code_s.a_n = 3'b110;
            else              code_s.a_n = 3'b111;
        end
    end

    // Output code, change strobe and change counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_r    <= IDLE_CODE;
            chg_r     <= 1'b0;
            chg_cnt_r <= {CNT_W{1'b0}};
        end else begin
            code_r <= code_s;
            if (code_s != code_r) begin
                chg_r     <= 1'b1;
                chg_cnt_r <= chg_cnt_r + CNT_W'(1);
            end else begin
                chg_r     <= 1'b0;
                chg_cnt_r <= chg_cnt_r;
            end
        end
    end

    assign a_n     = code_r.a_n;
    assign gs_n    = code_r.gs_n;
    assign eo_n    = code_r.eo_n;
    assign chg     = chg_r;
    assign chg_cnt = chg_cnt_r;

endmodule

// File: tb/tb_ttl74148_sync.sv
// Directed-vector bench for ttl74148_sync with a short debounce window (latency 7 edges).
module tb_ttl74148_sync;

    logic       clk;
    logic       rst;
    logic       ei_n;
    logic [7:0] i_n;
    logic [2:0] a_n;
    logic       gs_n;
    logic       eo_n;
    logic       chg;
    logic [7:0] chg_cnt;

    int checks = 0;
    int errors = 0;
    logic chg_seen;

    ttl74148_sync #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ei_n    (ei_n),
        .i_n     (i_n),
        .a_n     (a_n),
        .gs_n    (gs_n),
        .eo_n    (eo_n),
        .chg     (chg),
        .chg_cnt (chg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_code(input string tag, input logic [2:0] ea, input logic egs,
                              input logic eeo, input logic echg, input logic [7:0] ecnt);
        check({tag, "_a_n"},  32'(a_n),     32'(ea));
        check({tag, "_gs_n"}, 32'(gs_n),    32'(egs));
        check({tag, "_eo_n"}, 32'(eo_n),    32'(eeo));
        check({tag, "_chg"},  32'(chg),     32'(echg));
        check({tag, "_cnt"},  32'(chg_cnt), 32'(ecnt));
    endtask

    // Call right after driving a new input: old code for 6 edges, new code with chg on edge 7.
    task automatic latency(input string tag,
                           input logic [2:0] pa, input logic pgs, input logic peo, input logic [7:0] pcnt,
                           input logic [2:0] na, input logic ngs, input logic neo, input logic [7:0] ncnt);
        step(6);
        check_code({tag, "_pre"}, pa, pgs, peo, 1'b0, pcnt);
        step(1);
        check_code({tag, "_post"}, na, ngs, neo, 1'b1, ncnt);
        step(1);
        check({tag, "_chg_drop"}, 32'(chg), 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        ei_n = 1'b1;
        i_n  = 8'hFF;
        step(3);
        rst = 1'b0;
        ei_n = 1'b0;
        i_n  = 8'h00;
        step(3);
        rst = 1'b1;
        #1;
        check_code("rst_async", 3'b111, 1'b1, 1'b1, 1'b0, 8'd0);
        ei_n = 1'b1;
        i_n  = 8'hFF;
        step(2);
        rst = 1'b0;
        chg_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            chg_seen = chg_seen | chg;
        end
        check_code("reset_idle", 3'b111, 1'b1, 1'b1, 1'b0, 8'd0);
        check("reset_no_chg", 32'(chg_seen), 32'd0);

        ei_n = 1'b0;
        i_n  = 8'hFF;
        latency("enable_none", 3'b111, 1'b1, 1'b1, 8'd0, 3'b111, 1'b1, 1'b0, 8'd1);

        i_n = 8'b1101_0111;
        latency("bits5_3", 3'b111, 1'b1, 1'b0, 8'd1, 3'b010, 1'b0, 1'b1, 8'd2);

        i_n = 8'b1101_1111;
        chg_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            chg_seen = chg_seen | chg;
        end
        check("low_prio_no_chg", 32'(chg_seen), 32'd0);
        check_code("low_prio_hold", 3'b010, 1'b0, 1'b1, 1'b0, 8'd2);

        chg_seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            i_n = (j % 2 == 0) ? 8'hFE : 8'hFF;
            for (int c = 0; c < 2; c++) begin
                step(1);
                chg_seen = chg_seen | chg;
            end
        end
        check("bounce_no_chg", 32'(chg_seen), 32'd0);
        check_code("bounce_hold", 3'b010, 1'b0, 1'b1, 1'b0, 8'd2);
        i_n = 8'hFE;
        latency("bounce_settle", 3'b010, 1'b0, 1'b1, 8'd2, 3'b111, 1'b0, 1'b1, 8'd3);

        i_n = 8'hBF;
        latency("bit6", 3'b111, 1'b0, 1'b1, 8'd3, 3'b001, 1'b0, 1'b1, 8'd4);
        ei_n = 1'b1;
        latency("disable", 3'b001, 1'b0, 1'b1, 8'd4, 3'b111, 1'b1, 1'b1, 8'd5);

        ei_n = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        check_code("rst_mid", 3'b111, 1'b1, 1'b1, 1'b0, 8'd0);
        step(1);
        rst = 1'b0;
        latency("after_rst", 3'b111, 1'b1, 1'b1, 8'd0, 3'b001, 1'b0, 1'b1, 8'd1);

        ei_n = 1'b1;
        rst  = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);
        check_code("wrap_start", 3'b111, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int n = 1; n <= 257; n++) begin
            ei_n = ~ei_n;
            step(8);
            if (n == 256) begin
                check("wrap_256", 32'(chg_cnt), 32'd0);
            end
        end
        check_code("wrap_257", 3'b001, 1'b0, 1'b1, 1'b0, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
